uart_rx: RTL
============

# uart_rx

Serial UART receiver that deserialises an asynchronous line into DATA_WIDTH-bit words and pushes each valid word into the downstream receive FIFO through its write-side interface (wr, w_data, full). It contains its own programmable 16x oversampling tick generator, a two-flop input synchroniser, false-start rejection, and framing and overrun detection.

## Interface
- DATA_WIDTH, 8: data bits per frame, sent LSB first.
- SB_TICK, 16: oversampling ticks spent in STOP. 16, 24 or 32 gives 1, 1.5 or 2 stop bits.
- DVSR_WIDTH, 11: width of the baud divisor input.
- clk  in  1: single clock; all logic on its rising edge.
- reset  in  1: asynchronous, active-low reset.
- rx  in  1: raw serial line, idle high, asynchronous to clk.
- dvsr  in  DVSR_WIDTH: tick period minus one, in clk cycles. One tick = 1/16 bit time.
- full  in  1: downstream FIFO full flag.
- wr  out  1: one-cycle write strobe to the FIFO.
- w_data  out  DATA_WIDTH: received word. Valid while wr=1; held until the next write.
- frame_err  out  1: one-cycle pulse when the stop bit is sampled low.
- overrun  out  1: one-cycle pulse when a good frame completes while full=1.
- busy  out  1: high whenever the FSM is not in IDLE.

## Operation
- Synchroniser: two flops on rx, both reset to 1. rx_s is the second flop. A third flop, rx_d, holds the previous rx_s for falling-edge detection.
- Tick generator: counter runs 0..dvsr. tick=1 for one cycle when the counter equals dvsr, then the counter wraps to 0.
  - Period is dvsr+1 cycles; dvsr=0 gives a tick every cycle.
  - The counter is free-running. A new dvsr value takes effect from the next wrap, and a counter already above a lowered dvsr wraps at its maximum.
- Counters: s (4 bits) counts ticks within a bit; n counts data bits. The shift register b is DATA_WIDTH bits.
- FSM state IDLE:
  - On a falling edge (rx_d=1, rx_s=0), clear s and go to START.
  - A line held low does not restart the FSM; it re-arms only after rx_s returns high.
- FSM state START: on tick, if s=7, sample rx_s.
  - rx_s=0: clear s and n, go to DATA.
  - rx_s=1: glitch; return to IDLE with no output.
  - Otherwise on tick, s++.
- FSM state DATA: on tick, if s=15, shift b <= {rx_s, b[DATA_WIDTH-1:1]} and clear s.
  - If n=DATA_WIDTH-1, go to STOP; else n++.
  - Otherwise on tick, s++.
- FSM state STOP: on tick, if s=SB_TICK-1, sample rx_s and go to IDLE.
  - rx_s=1 and full=0: wr=1, w_data<=b.
  - rx_s=1 and full=1: overrun=1; word dropped, w_data unchanged.
  - rx_s=0: frame_err=1; no write.
  - Otherwise on tick, s++.
- wr is never asserted while full=1.
- frame_err, overrun and wr are mutually exclusive.

## Timing
- Reset values: wr=0, w_data=0, frame_err=0, overrun=0, busy=0. FSM in IDLE, all counters 0, synchroniser flops 1.
- Reset asserted mid-frame: immediate return to IDLE; the partial word is discarded and no pulse is produced.
- wr, w_data, frame_err and overrun are registered. They assert in the cycle after the edge that processes the final STOP tick, for exactly one cycle.
- Input latency: 2 clk from rx change to rx_s.
- Start detection jitter is at most one tick period, due to the free-running tick.
- Sample points:
  - Start bit at its midpoint (8th tick after the edge is seen).
  - Each data bit and the stop bit at their midpoints, 16 ticks apart.
- Back-to-back frames: the FSM reaches IDLE at the stop-bit midpoint, then catches the next falling edge with no lost frame.
- busy rises the cycle after the falling edge is detected and falls the cycle after the return to IDLE.

## Test plan
- dvsr=3 (4 clk/tick, 64 clk/bit), full=0; send 0xA5 8N1 -> exactly one wr pulse with w_data=0xA5; frame_err=0, overrun=0.
- rx low for 16 clk, then high -> no wr and no frame_err; busy returns to 0 by the START midpoint check.
- Send 0x3C with stop bit 0, then rx high for 2 bits, then 0x55 -> frame_err pulse with no wr for the first frame; wr with w_data=0x55 for the second.
- full=1 during frame 0x81, then full=0 for frame 0x7E -> overrun pulse with no wr, w_data still holding the old value; then wr with w_data=0x7E.
- Frames 0x00, 0xFF, 0x5A back-to-back with no idle gap, at dvsr=0 and again at dvsr=26 -> three wr pulses in order with correct data.
- Assert reset during the 4th data bit of 0x12, release it, then send 0x34 -> all outputs 0 during reset, no spurious wr; then wr with w_data=0x34.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first, with false-start rejection,
// framing and overrun detection. Good words are pushed into a downstream
// FIFO through its write side (o_wr / o_w_data / i_full).
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on the synchronised input
// START | counting to the start-bit midpoint to confirm a real start
// DATA  | sampling DATA_WIDTH data bits at their midpoints
// STOP  | waiting SB_TICK ticks, then sampling the stop bit

module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16,
    parameter int DVSR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx,
    input  logic [DVSR_WIDTH-1:0] i_dvsr,
    input  logic                  i_full,
    output logic                  o_wr,
    output logic [DATA_WIDTH-1:0] o_w_data,
    output logic                  o_frame_err,
    output logic                  o_overrun,
    output logic                  o_busy
);

    // s must reach SB_TICK-1 in STOP, so it widens for 1.5 / 2 stop bits
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic                  r_rx_d;
    logic [DVSR_WIDTH-1:0] r_tick_cnt;
    state_t                r_state;
    logic [SW-1:0]         r_s;
    logic [NW-1:0]         r_n;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_w_data;
    logic                  r_frame_err;
    logic                  r_overrun;

    logic                  w_tick;
    logic                  w_fall;
    state_t                w_state_nxt;
    logic [SW-1:0]         w_s_nxt;
    logic [NW-1:0]         w_n_nxt;
    logic [DATA_WIDTH-1:0] w_b_nxt;
    logic                  w_wr_nxt;
    logic [DATA_WIDTH-1:0] w_w_data_nxt;
    logic                  w_frame_err_nxt;
    logic                  w_overrun_nxt;

    assign w_tick = (r_tick_cnt == i_dvsr);
    assign w_fall = r_rx_d & ~r_rx_s;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    // Free-running tick counter; a count already past a lowered divisor
    // simply rolls over at its natural maximum
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + DVSR_WIDTH'(1);
        end
    end

    // FSM, datapath registers and registered output pulses
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_s         <= '0;
            r_n         <= '0;
            r_b         <= '0;
            r_wr        <= 1'b0;
            r_w_data    <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_s         <= w_s_nxt;
            r_n         <= w_n_nxt;
            r_b         <= w_b_nxt;
            r_wr        <= w_wr_nxt;
            r_w_data    <= w_w_data_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt     = r_state;
        w_s_nxt         = r_s;
        w_n_nxt         = r_n;
        w_b_nxt         = r_b;
        w_wr_nxt        = 1'b0;
        w_w_data_nxt    = r_w_data;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_s_nxt     = '0;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_s == SW'(7)) begin
                        if (!r_rx_s) begin
                            w_s_nxt     = '0;
                            w_n_nxt     = '0;
                            w_state_nxt = DATA;
                        end else begin
                            // line went back high before midpoint: glitch
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_s == SW'(15)) begin
                        w_b_nxt = {r_rx_s, r_b[DATA_WIDTH-1:1]};
                        w_s_nxt = '0;
                        if (r_n == NW'(DATA_WIDTH - 1)) begin
                            w_state_nxt = STOP;
                        end else begin
                            w_n_nxt = r_n + NW'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_s == SW'(SB_TICK - 1)) begin
                        w_state_nxt = IDLE;
                        if (!r_rx_s) begin
                            w_frame_err_nxt = 1'b1;
                        end else if (i_full) begin
                            w_overrun_nxt = 1'b1;
                        end else begin
                            w_wr_nxt     = 1'b1;
                            w_w_data_nxt = r_b;
                        end
                    end else begin
                        w_s_nxt = r_s + SW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_wr        = r_wr;
    assign o_w_data    = r_w_data;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;
    assign o_busy      = (r_state != IDLE);

endmodule
